// File: rtl/sram_arb_pkg.sv
// Shared constants and id helpers for the three-port SRAM arbiter.
// Master i travels on the memory port under transaction id i+1; id 0 means idle.
package sram_arb_pkg;
  localparam int NMASTER = 3;
  localparam int ID_W    = 2;

  function automatic logic [ID_W-1:0] id_of(input logic [ID_W-1:0] m);
    return m + 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] master_of(input logic [ID_W-1:0] id);
    return id - 1'b1;
  endfunction

  // One-hot master select for a returned id; id 0 selects nobody.
  function automatic logic [NMASTER-1:0] onehot_of_id(input logic [ID_W-1:0] id);
    logic [NMASTER-1:0] oh;
    oh = '0;
    if (id != '0) oh[master_of(id)] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker: the first requester found scanning
// ptr, ptr+1, ptr+2 (mod 3) wins.
module rr_pick3
  import sram_arb_pkg::*;
(
  input  logic [NMASTER-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt
);
  logic [ID_W:0] slot;

  // Scan from the far end so the nearest requester to ptr is written last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    slot      = '0;
    for (int k = NMASTER - 1; k >= 0; k--) begin
      slot = {1'b0, ptr} + 3'(k);
      if (slot >= 3'(NMASTER)) slot = slot - 3'(NMASTER);
      if (req[slot[ID_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt       = slot[ID_W-1:0];
      end
    end
  end
endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one burst SRAM controller port between three
// masters; requests are tagged with id i+1 and read words are steered back by id.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int BURST  = 4
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic [NMASTER-1:0]        m_read,
  input  logic [NMASTER-1:0]        m_write,
  input  logic [NMASTER*ADDR_W-1:0] m_address,
  input  logic [NMASTER*32-1:0]     m_writedata,
  input  logic [NMASTER*4-1:0]      m_writedatamask,
  output logic [NMASTER-1:0]        m_waitrequest,
  output logic [31:0]               m_readdata,
  output logic [NMASTER-1:0]        m_readdatavalid,
  input  logic                      mem_waitrequest,
  output logic [ID_W-1:0]           mem_id,
  output logic [ADDR_W-1:0]         mem_address,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [31:0]               mem_writedata,
  output logic [3:0]                mem_writedatamask,
  input  logic [31:0]               mem_readdata,
  input  logic [ID_W-1:0]           mem_readdataid
);
  logic [NMASTER-1:0] req;
  logic [ID_W-1:0]    ptr, lgnt, pick_gnt, gnt, sel;
  logic               lock, pick_valid, gnt_valid;
  logic [NMASTER-1:0] gnt_onehot;

  logic [ADDR_W-1:0] addr_arr [NMASTER];
  logic [31:0]       wdata_arr[NMASTER];
  logic [3:0]        mask_arr [NMASTER];

  genvar gi;
  generate
    for (gi = 0; gi < NMASTER; gi++) begin : g_unpack
      assign addr_arr[gi]  = m_address[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = m_writedata[gi*32 +: 32];
      assign mask_arr[gi]  = m_writedatamask[gi*4 +: 4];
    end
  endgenerate

  assign req = m_read | m_write;

  rr_pick3 u_pick (
    .req       (req),
    .ptr       (ptr),
    .gnt_valid (pick_valid),
    .gnt       (pick_gnt)
  );

  // A stalled grant stays pinned to lgnt so the controller sees a stable request.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    if (rst_n) begin
      if (lock) begin
        gnt_valid = 1'b1;
        gnt       = lgnt;
      end else begin
        gnt_valid = pick_valid;
        gnt       = pick_gnt;
      end
    end
  end

  assign sel        = gnt_valid ? gnt : '0;
  assign gnt_onehot = gnt_valid ? (NMASTER'(1) << gnt) : '0;

  assign mem_id            = gnt_valid ? id_of(gnt) : '0;
  assign mem_address       = addr_arr[sel];
  assign mem_writedata     = wdata_arr[sel];
  assign mem_writedatamask = mask_arr[sel];
  assign mem_read          = gnt_valid & m_read[sel];
  assign mem_write         = gnt_valid & m_write[sel] & ~m_read[sel];
  assign m_waitrequest     = {NMASTER{mem_waitrequest}} | ~gnt_onehot;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      ptr             <= '0;
      lock            <= 1'b0;
      lgnt            <= '0;
      m_readdatavalid <= '0;
      m_readdata      <= '0;
    end else begin
      if (gnt_valid && !mem_waitrequest) begin
        ptr  <= (gnt == ID_W'(NMASTER - 1)) ? '0 : gnt + 1'b1;
        lock <= 1'b0;
      end else if (gnt_valid && mem_waitrequest && !lock) begin
        lock <= 1'b1;
        lgnt <= gnt;
      end
      m_readdatavalid <= onehot_of_id(mem_readdataid);
      if (mem_readdataid != '0) m_readdata <= mem_readdata;
    end
  end

  a_one_op: assert property (@(posedge clock) disable iff (!rst_n) (m_read & m_write) == '0);
  a_burst:  assert property (@(posedge clock) BURST > 0);
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: accepts and read responses are checked by a
// negedge monitor against expectation queues filled by the stimulus.
module tb_sram_arbiter;
  localparam int AW = 30;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [2:0]  m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [89:0] m_address;
  logic [95:0] m_writedata;
  logic [11:0] m_writedatamask;
  logic [31:0] m_readdata, mem_readdata, mem_writedata;
  logic        mem_waitrequest, mem_read, mem_write;
  logic [1:0]  mem_id, mem_readdataid;
  logic [29:0] mem_address;
  logic [3:0]  mem_writedatamask;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  id;
    logic [29:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  mask;
  } acc_t;

  typedef struct {
    logic [2:0]  valid;
    logic [31:0] data;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];

  sram_arbiter #(.ADDR_W(AW), .BURST(4)) dut (
    .clock(clock), .rst_n(rst_n),
    .m_read(m_read), .m_write(m_write), .m_address(m_address),
    .m_writedata(m_writedata), .m_writedatamask(m_writedatamask),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .mem_waitrequest(mem_waitrequest),
    .mem_id(mem_id), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_writedatamask(mem_writedatamask), .mem_readdata(mem_readdata),
    .mem_readdataid(mem_readdataid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_addr(input int i, input logic [29:0] a);
    m_address[i*AW +: AW] = a;
  endtask

  task automatic exp_acc(input logic [1:0] id, input logic [29:0] a, input logic rd,
                         input logic wr, input logic [31:0] wd, input logic [3:0] mk);
    acc_t e;
    e.id = id; e.addr = a; e.rd = rd; e.wr = wr; e.wd = wd; e.mask = mk;
    acc_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic [2:0] v, input logic [31:0] d);
    rsp_t e;
    e.valid = v; e.data = d;
    rsp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: one line per observed transaction, popped against the queues.
  always @(negedge clock) begin
    if ((mem_read || mem_write) && !mem_waitrequest) begin
      if (acc_q.size() == 0) begin
        chk("unexpected_accept", {32'b0, mem_id, mem_address}, 64'h0);
      end else begin
        acc_t e;
        e = acc_q.pop_front();
        $display("accept id=%0d addr=0x%0h rd=%0b wr=%0b", mem_id, mem_address, mem_read, mem_write);
        chk("acc_id", 64'(mem_id), 64'(e.id));
        chk("acc_addr", 64'(mem_address), 64'(e.addr));
        chk("acc_rdwr", {62'b0, mem_read, mem_write}, {62'b0, e.rd, e.wr});
        if (e.wr) begin
          chk("acc_wdata", 64'(mem_writedata), 64'(e.wd));
          chk("acc_mask", 64'(mem_writedatamask), 64'(e.mask));
        end
      end
    end
    if (m_readdatavalid != 3'b000) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_valid", 64'(m_readdatavalid), 64'h0);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        $display("response valid=%03b data=0x%08h", m_readdatavalid, m_readdata);
        chk("rsp_valid", 64'(m_readdatavalid), 64'(r.valid));
        chk("rsp_data", 64'(m_readdata), 64'(r.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] id_data [4];
  logic [1:0]  id_seq  [4];
  logic [2:0]  id_vld  [4];

  initial begin
    rst_n = 1'b0; m_read = '0; m_write = '0; m_address = '0; m_writedata = '0;
    m_writedatamask = '0; mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdataid = '0;

    // Reset: requests are suppressed and response registers are clear.
    tick();
    m_read = 3'b111;
    @(negedge clock);
    chk("rst_mem_rdwr", {62'b0, mem_read, mem_write}, 64'h0);
    chk("rst_mem_id", 64'(mem_id), 64'h0);
    chk("rst_waitreq", 64'(m_waitrequest), 64'h7);
    chk("rst_valid", 64'(m_readdatavalid), 64'h0);
    chk("rst_rdata", 64'(m_readdata), 64'h0);
    tick();
    m_read = '0;
    rst_n = 1'b1;

    // Single master read, accepted in the same cycle; 4-word burst back.
    set_addr(1, 30'h0000100);
    m_read = 3'b010;
    exp_acc(2'd2, 30'h0000100, 1'b1, 1'b0, 32'h0, 4'h0);
    @(negedge clock);
    chk("single_mem_id", 64'(mem_id), 64'h2);
    chk("single_waitreq", 64'(m_waitrequest), 64'h5);
    tick();
    m_read = '0;
    for (int k = 0; k < 4; k++) begin
      mem_readdataid = 2'd2;
      mem_readdata = 32'hDEADBEEF + 32'(k);
      exp_rsp(3'b010, 32'hDEADBEEF + 32'(k));
      tick();
      chk("burst_latency", 64'(m_readdatavalid), 64'h2);
    end
    mem_readdataid = 2'd0;
    tick();

    // Write passthrough from master 0 (ptr is 2, only master 0 asks).
    set_addr(0, 30'h000002A);
    m_writedata[31:0] = 32'h12345678;
    m_writedatamask[3:0] = 4'b0011;
    m_write = 3'b001;
    exp_acc(2'd1, 30'h000002A, 1'b0, 1'b1, 32'h12345678, 4'b0011);
    @(negedge clock);
    chk("wr_mem_write", 64'(mem_write), 64'h1);
    tick();
    m_write = '0;
    chk("wr_no_valid", 64'(m_readdatavalid), 64'h0);

    // Id routing 1,0,3,2; id 0 holds the previous data.
    id_seq[0] = 2'd1; id_seq[1] = 2'd0; id_seq[2] = 2'd3; id_seq[3] = 2'd2;
    id_vld[0] = 3'b001; id_vld[1] = 3'b000; id_vld[2] = 3'b100; id_vld[3] = 3'b010;
    id_data[0] = 32'hA1A1A1A1; id_data[1] = 32'h0BADF00D;
    id_data[2] = 32'hA3A3A3A3; id_data[3] = 32'hA2A2A2A2;
    for (int s = 0; s < 4; s++) begin
      mem_readdataid = id_seq[s];
      mem_readdata = id_data[s];
      if (id_vld[s] != 3'b000) exp_rsp(id_vld[s], id_data[s]);
      tick();
      chk("route_valid", 64'(m_readdatavalid), 64'(id_vld[s]));
      if (s == 1) chk("route_hold", 64'(m_readdata), 64'hA1A1A1A1);
    end
    mem_readdataid = 2'd0;
    tick();

    // Fairness from reset: all three hold writes, grants 0,1,2,0,1,2.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_addr(i, 30'(32'h10 + 32'(i)));
      m_writedata[i*32 +: 32] = 32'h1000 + 32'(i);
      m_writedatamask[i*4 +: 4] = 4'hF;
    end
    m_write = 3'b111;
    for (int n = 0; n < 6; n++)
      exp_acc(2'(n % 3 + 1), 30'(32'h10 + 32'(n % 3)), 1'b0, 1'b1, 32'h1000 + 32'(n % 3), 4'hF);
    repeat (6) tick();
    m_write = '0;

    // Stall lock: master 2 pinned while the controller stalls; master 0 waits.
    set_addr(2, 30'h0000300);
    set_addr(0, 30'h00000AA);
    m_read = 3'b100;
    mem_waitrequest = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("stall_mem_id", 64'(mem_id), 64'h3);
      chk("stall_addr", 64'(mem_address), 64'h300);
      chk("stall_waitreq", 64'(m_waitrequest), 64'h7);
      tick();
      if (c == 0) m_read = 3'b101;
    end
    mem_waitrequest = 1'b0;
    exp_acc(2'd3, 30'h0000300, 1'b1, 1'b0, 32'h0, 4'h0);
    exp_acc(2'd1, 30'h00000AA, 1'b1, 1'b0, 32'h0, 4'h0);
    tick();
    m_read = 3'b001;
    tick();
    m_read = '0;

    // Bring ptr to 2 via master 1, then lock on master 2 and reset mid-burst.
    set_addr(1, 30'h0000111);
    m_read = 3'b010;
    exp_acc(2'd2, 30'h0000111, 1'b1, 1'b0, 32'h0, 4'h0);
    tick();
    set_addr(2, 30'h0000222);
    m_read = 3'b100;
    mem_waitrequest = 1'b1;
    tick();
    rst_n = 1'b0;
    m_read = '0;
    mem_waitrequest = 1'b0;
    mem_readdataid = 2'd1;
    mem_readdata = 32'h55555555;
    @(negedge clock);
    chk("rst2_mem_id", 64'(mem_id), 64'h0);
    tick();
    rst_n = 1'b1;
    mem_readdataid = 2'd0;
    @(negedge clock);
    chk("rst2_valid", 64'(m_readdatavalid), 64'h0);
    chk("rst2_rdata", 64'(m_readdata), 64'h0);
    tick();
    set_addr(0, 30'h00000A0);
    set_addr(1, 30'h00001A0);
    m_read = 3'b011;
    exp_acc(2'd1, 30'h00000A0, 1'b1, 1'b0, 32'h0, 4'h0);
    exp_acc(2'd2, 30'h00001A0, 1'b1, 1'b0, 32'h0, 4'h0);
    @(negedge clock);
    chk("rst2_first_gnt", 64'(mem_id), 64'h1);
    tick();
    m_read = 3'b010;
    tick();
    m_read = '0;

    repeat (4) tick();
    chk("acc_queue_drained", 64'(acc_q.size()), 64'h0);
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
